// File: rtl/game_flow_controller_pkg.sv
// Shared types for the Tetris game-flow sequencer.
// State encodings are visible to every consumer of game_current_state.
package game_flow_controller_pkg;

  typedef enum logic [2:0] {
    INITIAL      = 3'd0,
    WAIT_INPUT   = 3'd1,
    MOVE_PIECE   = 3'd2,
    ROTATE_PIECE = 3'd3,
    DROP_PIECE   = 3'd4,
    CLEAR_ROW    = 3'd5,
    GAME_OVER    = 3'd6
  } state_e;

  localparam int unsigned DROP_TICKS_DEF = 25_000_000;
  localparam int unsigned TIMEOUT_DEF    = 1024;

  function automatic logic is_busy(state_e s);
    return s inside {MOVE_PIECE, ROTATE_PIECE,
                     DROP_PIECE, CLEAR_ROW};
  endfunction

  function automatic logic is_run(state_e s);
    return !(s inside {INITIAL, GAME_OVER});
  endfunction

endpackage

// File: rtl/game_flow_controller_if.sv
// Player buttons, unit done/status lines and sequencer outputs.
// master = sequencer side, slave = environment side.
interface game_flow_controller_if;

  logic       btn_start;
  logic       btn_left;
  logic       btn_right;
  logic       btn_rotate;
  logic       btn_down;
  logic [1:0] speed_level;
  logic       done_move;
  logic       done_rotate;
  logic       done_drop;
  logic       landed;
  logic       done_clear;
  logic       spawn_blocked;
  logic [2:0] game_current_state;
  logic       move_dir;
  logic       busy;
  logic       err_timeout;

  modport master (
    input  btn_start, btn_left, btn_right,
    input  btn_rotate, btn_down, speed_level,
    input  done_move, done_rotate, done_drop,
    input  landed, done_clear, spawn_blocked,
    output game_current_state, move_dir,
    output busy, err_timeout
  );

  modport slave (
    output btn_start, btn_left, btn_right,
    output btn_rotate, btn_down, speed_level,
    output done_move, done_rotate, done_drop,
    output landed, done_clear, spawn_blocked,
    input  game_current_state, move_dir,
    input  busy, err_timeout
  );

endinterface

// File: rtl/game_flow_controller_drop_tick_timer.sv
// Gravity timer: period = DROP_TICKS >> speed, one-cycle tick on wrap.
// Clear has priority over counting; disabled timer holds its count.
module game_flow_controller_drop_tick_timer #(
  parameter int unsigned DROP_TICKS = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [1:0] speed_i,
  output logic       tick_o
);

  localparam int CW = $clog2(DROP_TICKS + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] period, last;

  // >= keeps a speed-up mid-count from running the counter to wrap
  always_comb begin
    period = CW'(DROP_TICKS) >> speed_i;
    last   = (period == '0) ? '0 : period - CW'(1);
    tick_o = en_i && (cnt_q >= last);
    cnt_d  = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (tick_o) cnt_d = '0;
    else if (en_i)   cnt_d = cnt_q + CW'(1);
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/game_flow_controller.sv
// Tetris sequencer: arbitrates player/gravity requests, issues one
// operation at a time, waits for done, watchdogs stuck units.
module game_flow_controller
  import game_flow_controller_pkg::*;
#(
  parameter int unsigned DROP_TICKS = DROP_TICKS_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  game_flow_controller_if.master bus
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e          state_q, state_d;
  logic            dir_q, dir_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic            pend_q, pend_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic            tick;
  logic            run;
  logic            wd_exp;
  logic            enter_drop;
  logic            tmr_clr;

  assign run    = is_run(state_q);
  assign wd_exp = (wd_q == WW'(TIMEOUT - 1));

  game_flow_controller_drop_tick_timer #(
    .DROP_TICKS(DROP_TICKS)
  ) u_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (run),
    .clr_i  (tmr_clr),
    .speed_i(bus.speed_level),
    .tick_o (tick)
  );

  // next state, arbitration and watchdog exits; done beats timeout
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    err_d   = 1'b0;
    unique case (state_q)
      INITIAL:
        if (bus.btn_start) state_d = WAIT_INPUT;
      WAIT_INPUT: begin
        if (pend_q) begin
          state_d = DROP_PIECE;
        end else if (bus.btn_rotate) begin
          state_d = ROTATE_PIECE;
        end else if (bus.btn_left) begin
          state_d = MOVE_PIECE;
          dir_d   = 1'b0;
        end else if (bus.btn_right) begin
          state_d = MOVE_PIECE;
          dir_d   = 1'b1;
        end
      end
      MOVE_PIECE: begin
        if (bus.done_move) begin
          state_d = WAIT_INPUT;
        end else if (wd_exp) begin
          state_d = WAIT_INPUT;
          err_d   = 1'b1;
        end
      end
      ROTATE_PIECE: begin
        if (bus.done_rotate) begin
          state_d = WAIT_INPUT;
        end else if (wd_exp) begin
          state_d = WAIT_INPUT;
          err_d   = 1'b1;
        end
      end
      DROP_PIECE: begin
        if (bus.done_drop) begin
          state_d = bus.landed ? CLEAR_ROW
                               : WAIT_INPUT;
        end else if (wd_exp) begin
          state_d = WAIT_INPUT;
          err_d   = 1'b1;
        end
      end
      CLEAR_ROW: begin
        if (bus.done_clear) begin
          state_d = bus.spawn_blocked ? GAME_OVER
                                      : WAIT_INPUT;
        end else if (wd_exp) begin
          state_d = WAIT_INPUT;
          err_d   = 1'b1;
        end
      end
      GAME_OVER:
        if (bus.btn_start) state_d = INITIAL;
      default:
        state_d = INITIAL;
    endcase
  end

  // pending drop, watchdog and busy; clearing beats setting
  always_comb begin
    enter_drop = (state_d == DROP_PIECE) &&
                 (state_q != DROP_PIECE);
    tmr_clr    = (state_q == INITIAL) || enter_drop;
    busy_d     = is_busy(state_d);
    pend_d     = pend_q;
    if (tick || (bus.btn_down && run)) pend_d = 1'b1;
    if (tmr_clr) pend_d = 1'b0;
    wd_d = '0;
    if ((state_d == state_q) && is_busy(state_q))
      wd_d = wd_q + WW'(1);
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INITIAL;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.game_current_state = state_q;
  assign bus.move_dir           = dir_q;
  assign bus.busy               = busy_q;
  assign bus.err_timeout        = err_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller.
// Vector table plus hand-written multi-cycle sequences.
module tb_game_flow_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  game_flow_controller_if ifc();

  game_flow_controller #(
    .DROP_TICKS(16),
    .TIMEOUT   (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // in = {start,rot,left,right,down,dmove,drot,ddrop,landed}
  // o  = {busy,dir,err}
  typedef struct packed {
    logic [8:0] in;
    logic [2:0] st;
    logic [2:0] o;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string nm, input int act,
                     input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic clr_in();
    ifc.btn_start     = 1'b0;
    ifc.btn_left      = 1'b0;
    ifc.btn_right     = 1'b0;
    ifc.btn_rotate    = 1'b0;
    ifc.btn_down      = 1'b0;
    ifc.done_move     = 1'b0;
    ifc.done_rotate   = 1'b0;
    ifc.done_drop     = 1'b0;
    ifc.landed        = 1'b0;
    ifc.done_clear    = 1'b0;
    ifc.spawn_blocked = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int st();
    return int'(ifc.game_current_state);
  endfunction

  task automatic chk_all(input string nm, input int s,
                         input int b, input int d,
                         input int e);
    chk({nm, "_state"}, st(), s);
    chk({nm, "_busy"}, int'(ifc.busy), b);
    chk({nm, "_dir"}, int'(ifc.move_dir), d);
    chk({nm, "_err"}, int'(ifc.err_timeout), e);
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    clr_in();
    step();
    step();
    rst_n = 1'b1;
    chk_all(nm, 0, 0, 0, 0);
  endtask

  task automatic wait_st(input int s, input int budget,
                         output int n);
    n = 0;
    while (st() != s && n < budget) begin
      step();
      n++;
    end
    if (st() != s) n = -1;
  endtask

  task automatic pulse_start();
    ifc.btn_start = 1'b1;
    step();
    ifc.btn_start = 1'b0;
  endtask

  initial begin
    int n;
    clr_in();
    ifc.speed_level = 2'd0;

    // ---- reset state and start
    do_reset("rst");

    vt[0]  = {9'b100000000, 3'd1, 3'b000};
    vt[1]  = {9'b011000000, 3'd3, 3'b100};
    vt[2]  = {9'b000000000, 3'd3, 3'b100};
    vt[3]  = {9'b000001000, 3'd3, 3'b100};
    vt[4]  = {9'b000000100, 3'd1, 3'b000};
    vt[5]  = {9'b000000000, 3'd1, 3'b000};
    vt[6]  = {9'b001100000, 3'd2, 3'b100};
    vt[7]  = {9'b000001000, 3'd1, 3'b000};
    vt[8]  = {9'b000100000, 3'd2, 3'b110};
    vt[9]  = {9'b001001000, 3'd1, 3'b010};
    vt[10] = {9'b000000000, 3'd1, 3'b010};
    vt[11] = {9'b000010000, 3'd1, 3'b010};
    vt[12] = {9'b010000000, 3'd4, 3'b110};
    vt[13] = {9'b000000010, 3'd1, 3'b010};
    vt[14] = {9'b000000011, 3'd1, 3'b010};

    for (int i = 0; i < 15; i++) begin
      {ifc.btn_start, ifc.btn_rotate, ifc.btn_left,
       ifc.btn_right, ifc.btn_down, ifc.done_move,
       ifc.done_rotate, ifc.done_drop,
       ifc.landed} = vt[i].in;
      step();
      clr_in();
      chk_all($sformatf("v%0d", i), int'(vt[i].st),
              int'(vt[i].o[2]), int'(vt[i].o[1]),
              int'(vt[i].o[0]));
    end

    // ---- gravity at speed 2 (period 4)
    do_reset("t3_rst");
    ifc.speed_level = 2'd2;
    pulse_start();
    chk("t3_start", st(), 1);
    wait_st(4, 20, n);
    chk("t3_grav_lat", n, 5);
    chk("t3_busy", int'(ifc.busy), 1);
    ifc.done_drop = 1'b1;
    step();
    clr_in();
    chk("t3_nolandst", st(), 1);
    chk("t3_nolandbusy", int'(ifc.busy), 0);

    // ---- landing, clear timeout, game over
    wait_st(4, 20, n);
    chk("t4_grav_lat2", n, 4);
    ifc.done_drop = 1'b1;
    ifc.landed    = 1'b1;
    step();
    clr_in();
    chk("t4_clear", st(), 5);
    for (int k = 0; k < 7; k++) step();
    chk("t4_clr_hold", st(), 5);
    chk("t4_clr_noerr", int'(ifc.err_timeout), 0);
    step();
    chk("t4_clr_to_st", st(), 1);
    chk("t4_clr_to_err", int'(ifc.err_timeout), 1);
    step();
    chk("t4_pend_drop", st(), 4);
    chk("t4_err_pulse", int'(ifc.err_timeout), 0);
    ifc.done_drop = 1'b1;
    ifc.landed    = 1'b1;
    step();
    clr_in();
    chk("t4_clear2", st(), 5);
    ifc.done_clear    = 1'b1;
    ifc.spawn_blocked = 1'b1;
    step();
    clr_in();
    chk("t4_over", st(), 6);
    chk("t4_over_busy", int'(ifc.busy), 0);
    for (int k = 0; k < 8; k++) begin
      ifc.btn_down   = k[0];
      ifc.btn_left   = k[1];
      ifc.btn_rotate = ~k[0];
      ifc.btn_right  = k[2];
      ifc.done_move  = k[1];
      step();
      clr_in();
      chk($sformatf("t4_frozen%0d", k), st(), 6);
    end
    pulse_start();
    chk("t4_restart", st(), 0);
    step();
    step();
    chk("t4_init_hold", st(), 0);
    pulse_start();
    chk("t4_newgame", st(), 1);
    step();
    chk("t4_no_stale", st(), 1);

    // ---- move watchdog, then done on the last cycle
    do_reset("t5_rst");
    ifc.speed_level = 2'd0;
    pulse_start();
    ifc.btn_left = 1'b1;
    step();
    clr_in();
    chk("t5_move", st(), 2);
    for (int k = 0; k < 7; k++) step();
    chk("t5_hold", st(), 2);
    chk("t5_noerr", int'(ifc.err_timeout), 0);
    step();
    chk("t5_to_st", st(), 1);
    chk("t5_to_err", int'(ifc.err_timeout), 1);
    ifc.btn_right = 1'b1;
    step();
    clr_in();
    chk_all("t5_move2", 2, 1, 1, 0);
    for (int k = 0; k < 7; k++) step();
    ifc.done_move = 1'b1;
    step();
    clr_in();
    chk("t5_done_st", st(), 1);
    chk("t5_done_noerr", int'(ifc.err_timeout), 0);
    step();
    chk("t5_grav_busy", st(), 4);

    // ---- asynchronous reset mid-drop
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("t6_async", 0, 0, 0, 0);
    step();
    step();
    rst_n = 1'b1;
    pulse_start();
    chk("t6_start", st(), 1);
    step();
    chk("t6_nopend1", st(), 1);
    step();
    chk("t6_nopend2", st(), 1);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: sim time %0t", $time);
    $fatal(1);
  end

endmodule
